// File: rtl/audio_onset_engine.sv
`default_nettype none
// ============================================================================
// Module   : audio_onset_engine
// Purpose  : Time-multiplexed per-band envelope follower and onset detector.
// Revision : 1.0 - initial release
// ============================================================================
module audio_onset_engine #(
    parameter int W    = 8,
    parameter int NCH  = 6,
    parameter int K    = 4,
    parameter int RECT = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ready,
    input  logic [NCH*W-1:0]         band_data,
    input  logic [NCH-1:0]           ch_en,
    input  logic [W+$clog2(NCH)-1:0] thresh,
    input  logic                     ovr_clr,
    output logic [W+$clog2(NCH)-1:0] onset_sum,
    output logic [NCH-1:0]           onset_mask,
    output logic                     onset_flag,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     overrun
);

    localparam int SW = W + $clog2(NCH);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NCH - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   ch_idx_q, ch_idx_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [SW-1:0]   onset_sum_q, onset_sum_d;
    logic [NCH-1:0]  onset_mask_q, onset_mask_d;
    logic            onset_flag_q, onset_flag_d;
    logic            out_valid_q, out_valid_d;
    logic            overrun_q, overrun_d;

    logic [W-1:0]    samp_q [NCH];
    logic [W+K-1:0]  acc_q  [NCH];
    logic [W-1:0]    envp_q [NCH];

    logic            w_load;
    logic            w_band_we;
    logic [W-1:0]    w_samp;
    logic [W-1:0]    w_samp_neg;
    logic [W-1:0]    w_mag;
    logic [W+K-1:0]  w_acc_cur;
    logic [W+K-1:0]  w_acc_new;
    logic [W-1:0]    w_env_new;
    logic [W-1:0]    w_env_prev;
    logic [W:0]      w_diff;
    logic [W-1:0]    w_onset;
    logic [W-1:0]    w_contrib;
    logic            w_band_en;
    logic            w_band_hit;
    logic [SW-1:0]   w_sum_next;
    logic [NCH-1:0]  w_mask_next;

    // Single shared band datapath, steered by ch_idx_q.
    always_comb begin
        w_samp     = samp_q[ch_idx_q];
        // Negating -2^(W-1) yields 2^(W-1), which is exact when read unsigned.
        w_samp_neg = ~w_samp + W'(1);
        if (!w_samp[W-1]) begin
            w_mag = w_samp;
        end else if (RECT != 0) begin
            w_mag = '0;
        end else begin
            w_mag = w_samp_neg;
        end
        w_acc_cur   = acc_q[ch_idx_q];
        // acc stays <= 2^(W-1+K), so this modular sum never wraps.
        w_acc_new   = w_acc_cur - (w_acc_cur >> K) + {{K{1'b0}}, w_mag};
        w_env_new   = w_acc_new[W+K-1:K];
        w_env_prev  = envp_q[ch_idx_q];
        w_diff      = {1'b0, w_env_new} - {1'b0, w_env_prev};
        w_onset     = w_diff[W] ? '0 : w_diff[W-1:0];
        w_band_en   = ch_en[ch_idx_q];
        w_contrib   = w_band_en ? w_onset : '0;
        w_band_hit  = w_band_en && (w_onset != '0);
        w_sum_next  = sum_q + SW'(w_contrib);
        w_mask_next = mask_q | (NCH'(w_band_hit) << ch_idx_q);
    end

    always_comb begin
        state_d      = state_q;
        ch_idx_d     = ch_idx_q;
        sum_d        = sum_q;
        mask_d       = mask_q;
        onset_sum_d  = onset_sum_q;
        onset_mask_d = onset_mask_q;
        onset_flag_d = onset_flag_q;
        out_valid_d  = 1'b0;
        overrun_d    = overrun_q;
        w_load       = 1'b0;
        w_band_we    = 1'b0;

        if (ovr_clr) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ready) begin
                    w_load   = 1'b1;
                    ch_idx_d = '0;
                    sum_d    = '0;
                    mask_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                w_band_we = w_band_en;
                // A frame arriving mid-run is dropped; set wins over clear.
                if (ready) begin
                    overrun_d = 1'b1;
                end
                if (ch_idx_q == LAST_IDX) begin
                    onset_sum_d  = w_sum_next;
                    onset_mask_d = w_mask_next;
                    onset_flag_d = (w_sum_next >= thresh);
                    out_valid_d  = 1'b1;
                    ch_idx_d     = '0;
                    state_d      = IDLE;
                end else begin
                    ch_idx_d = ch_idx_q + CW'(1);
                    sum_d    = w_sum_next;
                    mask_d   = w_mask_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ch_idx_q     <= '0;
            sum_q        <= '0;
            mask_q       <= '0;
            onset_sum_q  <= '0;
            onset_mask_q <= '0;
            onset_flag_q <= 1'b0;
            out_valid_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_idx_q     <= ch_idx_d;
            sum_q        <= sum_d;
            mask_q       <= mask_d;
            onset_sum_q  <= onset_sum_d;
            onset_mask_q <= onset_mask_d;
            onset_flag_q <= onset_flag_d;
            out_valid_q  <= out_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                samp_q[i] <= '0;
                acc_q[i]  <= '0;
                envp_q[i] <= '0;
            end
        end else begin
            if (w_load) begin
                for (int i = 0; i < NCH; i++) begin
                    samp_q[i] <= band_data[i*W +: W];
                end
            end
            if (w_band_we) begin
                acc_q[ch_idx_q]  <= w_acc_new;
                envp_q[ch_idx_q] <= w_env_new;
            end
        end
    end

    assign onset_sum  = onset_sum_q;
    assign onset_mask = onset_mask_q;
    assign onset_flag = onset_flag_q;
    assign out_valid  = out_valid_q;
    assign busy       = (state_q == RUN);
    assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_onset_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_onset_engine
// Purpose  : Scoreboard bench for audio_onset_engine (W=8, NCH=4, K=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_onset_engine;

    localparam int W   = 8;
    localparam int NCH = 4;
    localparam int K   = 2;
    localparam int SW  = W + $clog2(NCH);

    typedef struct {
        logic [SW-1:0]  sum;
        logic [NCH-1:0] mask;
        logic           flag;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             ready = 1'b0;
    logic [NCH*W-1:0] band_data = '0;
    logic [NCH-1:0]   ch_en = 4'b1111;
    logic [SW-1:0]    thresh = 10'd10;
    logic             ovr_clr = 1'b0;

    logic [SW-1:0]    onset_sum0, onset_sum1;
    logic [NCH-1:0]   onset_mask0, onset_mask1;
    logic             onset_flag0, onset_flag1;
    logic             out_valid0, out_valid1;
    logic             busy0, busy1;
    logic             overrun0, overrun1;

    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    audio_onset_engine #(.W(W), .NCH(NCH), .K(K), .RECT(0)) dut0 (
        .clk(clk), .reset(reset), .ready(ready), .band_data(band_data),
        .ch_en(ch_en), .thresh(thresh), .ovr_clr(ovr_clr),
        .onset_sum(onset_sum0), .onset_mask(onset_mask0), .onset_flag(onset_flag0),
        .out_valid(out_valid0), .busy(busy0), .overrun(overrun0)
    );

    audio_onset_engine #(.W(W), .NCH(NCH), .K(K), .RECT(1)) dut1 (
        .clk(clk), .reset(reset), .ready(ready), .band_data(band_data),
        .ch_en(ch_en), .thresh(thresh), .ovr_clr(ovr_clr),
        .onset_sum(onset_sum1), .onset_mask(onset_mask1), .onset_flag(onset_flag1),
        .out_valid(out_valid1), .busy(busy1), .overrun(overrun1)
    );

    // Every out_valid pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (out_valid0 === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_out_valid: got pulse sum=%0d, want no output", onset_sum0);
            end else begin
                e = sb.pop_front();
                if (onset_sum0 !== e.sum || onset_mask0 !== e.mask || onset_flag0 !== e.flag)
                    $display("FAIL scoreboard: got sum=%0d mask=%b flag=%b, want sum=%0d mask=%b flag=%b",
                             onset_sum0, onset_mask0, onset_flag0, e.sum, e.mask, e.flag);
                else
                    passes++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NCH*W-1:0] d, input bit push,
                        input logic [SW-1:0] s, input logic [NCH-1:0] m, input logic f);
        exp_t e;
        if (push) begin
            e.sum  = s;
            e.mask = m;
            e.flag = f;
            sb.push_back(e);
        end
        band_data = d;
        ready     = 1'b1;
        tick();
        ready     = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int  n    = 0;
        bit  seen = 1'b0;
        while (!seen && n < 20) begin
            tick();
            n++;
            if (out_valid0 === 1'b1) seen = 1'b1;
        end
        lat = n;
        if (!seen) begin
            checks++;
            $display("FAIL out_valid_timeout: no pulse after %0d cycles, want one", n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        checks++; if (onset_sum0 !== '0) $display("FAIL reset_sum: got %0d want 0", onset_sum0); else passes++;
        checks++; if (onset_mask0 !== '0) $display("FAIL reset_mask: got %b want 0000", onset_mask0); else passes++;
        checks++; if (onset_flag0 !== 1'b0) $display("FAIL reset_flag: got %b want 0", onset_flag0); else passes++;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid0); else passes++;
        checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else passes++;
        checks++; if (overrun0 !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun0); else passes++;
        checks++; if (onset_sum1 !== '0) $display("FAIL reset_sum_rect1: got %0d want 0", onset_sum1); else passes++;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_envelope();
        int lat;
        send(32'h0000_0040, 1'b1, 10'd16, 4'b0001, 1'b1);
        checks++; if (busy0 !== 1'b1) $display("FAIL env_busy_run: got %b want 1", busy0); else passes++;
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL env_latency1: got %0d want 4", lat); else passes++;
        checks++; if (busy0 !== 1'b0) $display("FAIL env_busy_idle: got %b want 0", busy0); else passes++;
        send(32'h0000_0040, 1'b1, 10'd12, 4'b0001, 1'b1);
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL env_latency2: got %0d want 4", lat); else passes++;
        checks++; if (dut0.acc_q[0] !== 10'd112) $display("FAIL env_acc2: got %0d want 112", dut0.acc_q[0]); else passes++;
        send(32'h0000_0040, 1'b1, 10'd9, 4'b0001, 1'b0);
        wait_valid(lat);
        checks++; if (dut0.acc_q[0] !== 10'd148) $display("FAIL env_acc3: got %0d want 148", dut0.acc_q[0]); else passes++;
        repeat (3) tick();
        checks++; if (onset_sum0 !== 10'd9) $display("FAIL hold_sum: got %0d want 9", onset_sum0); else passes++;
        checks++; if (onset_mask0 !== 4'b0001) $display("FAIL hold_mask: got %b want 0001", onset_mask0); else passes++;
        checks++; if (onset_flag0 !== 1'b0) $display("FAIL hold_flag: got %b want 0", onset_flag0); else passes++;
        checks++; if (out_valid0 !== 1'b0) $display("FAIL hold_valid: got %b want 0", out_valid0); else passes++;
    endtask

    task automatic test_rectify();
        int lat;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        send(32'h0000_8000, 1'b1, 10'd32, 4'b0010, 1'b1);
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL rect_latency: got %0d want 4", lat); else passes++;
        checks++; if (out_valid1 !== 1'b1) $display("FAIL rect1_valid: got %b want 1", out_valid1); else passes++;
        checks++; if (onset_sum1 !== '0) $display("FAIL rect1_sum: got %0d want 0", onset_sum1); else passes++;
        checks++; if (onset_mask1 !== '0) $display("FAIL rect1_mask: got %b want 0000", onset_mask1); else passes++;
        checks++; if (onset_flag1 !== 1'b0) $display("FAIL rect1_flag: got %b want 0", onset_flag1); else passes++;
    endtask

    task automatic test_overrun();
        int lat;
        send(32'h0000_0040, 1'b1, 10'd16, 4'b0001, 1'b1);
        band_data = 32'h7F7F_7F7F;
        ready     = 1'b1;
        tick();
        ready     = 1'b0;
        band_data = '0;
        checks++; if (overrun0 !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun0); else passes++;
        wait_valid(lat);
        checks++; if (lat != 3) $display("FAIL ovr_latency: got %0d want 3 after drop", lat); else passes++;
        repeat (5) tick();
        checks++; if (overrun0 !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun0); else passes++;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun0 !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun0); else passes++;
        send(32'h0000_0000, 1'b1, 10'd0, 4'b0000, 1'b0);
        ready   = 1'b1;
        ovr_clr = 1'b1;
        tick();
        ready   = 1'b0;
        ovr_clr = 1'b0;
        checks++; if (overrun0 !== 1'b1) $display("FAIL ovr_set_priority: got %b want 1", overrun0); else passes++;
        wait_valid(lat);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        checks++; if (overrun0 !== 1'b0) $display("FAIL ovr_clear2: got %b want 0", overrun0); else passes++;
    endtask

    task automatic test_reset_midrun();
        int lat;
        send(32'h0000_0040, 1'b1, 10'd13, 4'b0001, 1'b1);
        wait_valid(lat);
        send(32'h0000_0040, 1'b0, '0, '0, 1'b0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        checks++; if (overrun0 !== 1'b1) $display("FAIL mid_pre_overrun: got %b want 1", overrun0); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (busy0 !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy0); else passes++;
        checks++; if (onset_sum0 !== '0) $display("FAIL mid_sum: got %0d want 0", onset_sum0); else passes++;
        checks++; if (onset_mask0 !== '0) $display("FAIL mid_mask: got %b want 0000", onset_mask0); else passes++;
        checks++; if (onset_flag0 !== 1'b0) $display("FAIL mid_flag: got %b want 0", onset_flag0); else passes++;
        checks++; if (overrun0 !== 1'b0) $display("FAIL mid_overrun: got %b want 0", overrun0); else passes++;
        checks++; if (dut0.acc_q[0] !== '0) $display("FAIL mid_acc: got %0d want 0", dut0.acc_q[0]); else passes++;
        repeat (2) tick();
        reset = 1'b1;
        repeat (8) tick();
        checks++; if (onset_sum0 !== '0) $display("FAIL mid_no_partial: got sum %0d want 0", onset_sum0); else passes++;
        send(32'h0000_0040, 1'b1, 10'd16, 4'b0001, 1'b1);
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL mid_latency: got %0d want 4", lat); else passes++;
    endtask

    task automatic test_ch_en();
        int lat;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        ch_en = 4'b1110;
        send(32'h0000_0040, 1'b1, 10'd0, 4'b0000, 1'b0);
        wait_valid(lat);
        checks++; if (dut0.acc_q[0] !== '0) $display("FAIL chen_acc_held: got %0d want 0", dut0.acc_q[0]); else passes++;
        ch_en = 4'b1111;
        send(32'h0000_0040, 1'b1, 10'd16, 4'b0001, 1'b1);
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL chen_latency: got %0d want 4", lat); else passes++;
    endtask

    task automatic test_back_to_back();
        int lat;
        send(32'h0000_0040, 1'b1, 10'd12, 4'b0001, 1'b1);
        wait_valid(lat);
        checks++; if (busy0 !== 1'b0) $display("FAIL b2b_idle_at_valid: got %b want 0", busy0); else passes++;
        thresh = 10'd14;
        send(32'hFD14_0040, 1'b1, 10'd14, 4'b0101, 1'b1);
        checks++; if (busy0 !== 1'b1) $display("FAIL b2b_accept: got %b want 1", busy0); else passes++;
        wait_valid(lat);
        checks++; if (lat != 4) $display("FAIL b2b_latency: got %0d want 4", lat); else passes++;
        tick();
        checks++; if (out_valid0 !== 1'b0) $display("FAIL b2b_pulse_width: got %b want 0", out_valid0); else passes++;
        thresh = 10'd10;
    endtask

    initial begin
        test_reset();
        test_envelope();
        test_rectify();
        test_overrun();
        test_reset_midrun();
        test_ch_en();
        test_back_to_back();
        repeat (6) tick();
        checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/audio_onset_engine.md
AUDIO_ONSET_ENGINE -- requirements
Module: audio_onset_engine

Interface
REQ-001 SHALL have parameter W, default 8: signed sample width per band.
REQ-002 SHALL have parameter NCH, default 6: number of bands, processed time-multiplexed.
REQ-003 SHALL have parameter K, default 4: envelope leak shift (one-pole IIR, 1 <= K <= 8).
REQ-004 SHALL have parameter RECT, default 0: 0 = full-wave rectify, 1 = half-wave rectify (negatives give 0).
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port ready, input, 1: sample strobe; one frame of all bands is valid while high.
REQ-008 SHALL have port band_data, input, NCH*W: band i in bits [i*W +: W], two's complement.
REQ-009 SHALL have port ch_en, input, NCH: per-band enable; a disabled band contributes 0 to the sum and its state is held.
REQ-010 SHALL have port thresh, input, W+clog2(NCH): onset threshold, unsigned.
REQ-011 SHALL have port ovr_clr, input, 1: clears overrun.
REQ-012 SHALL have port onset_sum, output, W+clog2(NCH): sum of per-band onset values for the last frame, unsigned.
REQ-013 SHALL have port onset_mask, output, NCH: bit i set when band i onset > 0.
REQ-014 SHALL have port onset_flag, output, 1: onset_sum >= thresh, registered with onset_sum.
REQ-015 SHALL have port out_valid, output, 1: one-cycle pulse when the outputs update.
REQ-016 SHALL have port busy, output, 1: high while a frame is being processed.
REQ-017 SHALL have port overrun, output, 1: sticky flag; a frame was dropped.

Function
REQ-018 SHALL use FSM states IDLE and RUN; IDLE with ready=1 SHALL latch band_data, set ch_idx=0, clear the running sum and enter RUN.
REQ-019 SHALL process band ch_idx in each RUN cycle, then increment ch_idx; after band NCH-1 it SHALL register outputs, pulse out_valid, and return to IDLE.
REQ-020 SHALL assert out_valid exactly NCH cycles after the edge that accepted ready; busy = (state==RUN).
REQ-021 SHALL accept a new frame in the same cycle that out_valid is high (state is IDLE then).
REQ-022 SHALL ignore ready while in RUN, leave the frame unprocessed, and set overrun; overrun SHALL hold until ovr_clr=1 or reset.
REQ-023 SHALL give overrun set priority when ready-in-RUN and ovr_clr occur in the same cycle.
REQ-024 Rectify: SHALL compute mag as W-bit unsigned; mag(-2^(W-1)) = 2^(W-1) with no wrap; when RECT=1, negative samples give mag = 0.
REQ-025 Envelope: SHALL keep per-band acc of W+K bits, unsigned, updated as acc <= acc + mag - (acc >> K); env = acc >> K (W bits).
REQ-026 Onset: SHALL compute diff = env_new - env_prev (signed, W+1 bits) and onset = diff > 0 ? diff : 0 (W bits); env_prev <= env_new.
REQ-027 Sum: SHALL add enabled-band onsets into a W+clog2(NCH)-bit accumulator, which cannot overflow.
REQ-028 SHALL leave acc, env_prev and the mask bit of a band with ch_en=0 unchanged or zero respectively, and add 0 for it.
REQ-029 SHALL store per-band state in arrays indexed by ch_idx; at most one band SHALL be updated per cycle.
REQ-030 SHALL hold onset_sum, onset_mask and onset_flag between out_valid pulses.

Reset
REQ-031 SHALL, on reset low at any time including mid-RUN, immediately set state=IDLE, ch_idx=0, all acc/env_prev=0, all outputs=0 and overrun=0.
REQ-032 SHALL, after reset rises, accept the first ready no earlier than the next rising clk edge, and SHALL NOT emit a partial frame.

Verification (W=8, NCH=4, K=2, RECT=0, ch_en=4'b1111, thresh=10)
REQ-033 SHALL be tested: band0=64, others 0, one frame -> out_valid 4 cycles later, onset_sum=16, onset_mask=0001, onset_flag=1.
REQ-034 SHALL be tested: the same frame repeated -> acc0=112, env=28, onset_sum=12, onset_flag=1; the third frame gives acc0=148, env=37, sum=9, flag=0.
REQ-035 SHALL be tested: band1=-128 from reset -> onset_sum=32 with RECT=0, and onset_sum=0, mask=0000 with RECT=1.
REQ-036 SHALL be tested: ready pulsed during RUN -> frame dropped, overrun=1, out_valid still at the original cycle; ovr_clr -> overrun=0.
REQ-037 SHALL be tested: reset asserted on the 2nd RUN cycle -> no out_valid, all outputs 0; the next frame with band0=64 gives onset_sum=16.
REQ-038 SHALL be tested: ch_en=4'b1110 with band0=64 -> onset_sum=0, mask=0000; re-enabling band0 with band0=64 gives onset_sum=16 (state was held).
